array_heap: RTL and testbench

- Parametrised, clocked successor to the generated per-test heap/array logic in our FPGA test harnesses.
- Manages up to NArrays fixed-area arrays, each holding NArea elements of MemoryElementWidth bits, in one heap memory.
- Supports allocation with reuse through a freed-array stack, per-array length tracking on write, bounds-checked reads and writes, and free.
- Sits between a program-execution engine and heap storage, behind a valid/ready command/response handshake.

---
 rtl/array_heap_pkg.sv | 34 +++
 rtl/array_free_stack.sv | 51 +++++
 rtl/array_heap.sv | 241 ++++++++++++++++++++++++
 tb/tb_array_heap.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_heap_pkg.sv
// Shared types and helpers for the array heap: command opcodes, the
// registered response record and the derived-width helper functions.
package array_heap_pkg;

   // Command opcodes; encodings 5..7 are rejected as illegal.
   typedef enum logic [2:0] {
      OP_ALLOC = 3'd0,
      OP_FREE  = 3'd1,
      OP_READ  = 3'd2,
      OP_WRITE = 3'd3,
      OP_SIZE  = 3'd4
   } op_t;

   // Widest element the response record can carry; narrower element widths
   // use the low bits and leave the rest at zero.
   localparam int unsigned RSP_DW = 64;

   // One registered response: result data plus the reject flag.
   typedef struct packed {
      logic [RSP_DW-1:0] data;
      logic              err;
   } rsp_t;

   // Array id width: ceil(log2(n)), never below one bit.
   function automatic int unsigned calc_aw(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Element index width: ceil(log2(n)), never below one bit.
   function automatic int unsigned calc_iw(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/array_free_stack.sv
// LIFO of freed array ids. Freed ids are handed back out most-recent-first.
// Depth equals the number of arrays, so legal use can never overflow it;
// push while full and pop while empty are ignored.
module array_free_stack
   import array_heap_pkg::*;
#(
   parameter int unsigned NArrays = 4,
   parameter int unsigned AW      = calc_aw(NArrays)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [AW-1:0] i_push_id,
   output logic [AW-1:0] o_top,
   output logic          o_empty
);

   localparam logic [AW:0] SP_ONE = (AW+1)'(1);

   logic [AW:0]   r_sp;
   logic [AW-1:0] r_mem [NArrays];
   logic [AW-1:0] w_top_idx;
   logic [AW-1:0] w_push_idx;
   logic          w_full;

   assign w_top_idx  = AW'(r_sp - SP_ONE);
   assign w_push_idx = AW'(r_sp);
   assign w_full     = (32'(r_sp) >= NArrays);
   assign o_empty    = (r_sp == '0);
   assign o_top      = o_empty ? '0 : r_mem[w_top_idx];

   // Stack pointer: counts stored ids, cleared by reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sp <= '0;
      end else if (i_push && !w_full) begin
         r_sp <= r_sp + SP_ONE;
      end else if (i_pop && !o_empty) begin
         r_sp <= r_sp - SP_ONE;
      end
   end

   // Id storage: contents are meaningless until pushed, so no reset.
   always_ff @(posedge clock) begin
      if (i_push && !w_full) begin
         r_mem[w_push_idx] <= i_push_id;
      end
   end

endmodule

// File: rtl/array_heap.sv
// Array heap: up to NArrays fixed-size arrays of NArea elements in one heap
// memory. Commands arrive over a valid/ready channel and each accepted
// command yields exactly one registered response one cycle later.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. The
// response register holds one entry, so cmd_ready = !rsp_valid || rsp_ready,
// allowing a new command in the same cycle the old response drains. While
// rsp_valid && !rsp_ready the response outputs stay frozen. A rejected command
// (rsp_err=1) returns data 0 and changes no state.
module array_heap
   import array_heap_pkg::*;
#(
   parameter int unsigned MemoryElementWidth = 12,
   parameter int unsigned NArrays            = 4,
   parameter int unsigned NArea              = 3,
   parameter int unsigned AW                 = calc_aw(NArrays),
   parameter int unsigned IW                 = calc_iw(NArea)
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [2:0]                    cmd_op,
   input  logic [AW-1:0]                 cmd_array,
   input  logic [IW-1:0]                 cmd_index,
   input  logic [MemoryElementWidth-1:0] cmd_data,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [MemoryElementWidth-1:0] rsp_data,
   output logic                          rsp_err,
   output logic [AW:0]                   in_use,
   output logic [AW:0]                   high_water
);

   localparam int unsigned HD  = NArrays * NArea;
   localparam int unsigned HAW = calc_aw(HD);
   localparam int unsigned LW  = IW + 1;
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
   localparam logic [LW-1:0] LEN_ONE = LW'(1);

   // Reset synchronizer output (asynchronous assert, synchronous release).
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   // Architectural state.
   logic                          r_rsp_valid;
   rsp_t                          r_rsp;
   logic [MemoryElementWidth-1:0] r_heap [HD];
   logic [LW-1:0]                 r_len [NArrays];
   logic [NArrays-1:0]            r_alloc;
   logic [AW:0]                   r_fresh;
   logic [AW:0]                   r_in_use;
   logic [AW:0]                   r_high_water;

   // Decode and datapath.
   op_t           w_op;
   rsp_t          w_rsp;
   logic          w_fire;
   logic          w_arr_in_range;
   logic          w_arr_live;
   logic          w_idx_in_area;
   logic          w_idx_in_len;
   logic          w_can_fresh;
   logic [LW-1:0] w_cur_len;
   logic [LW-1:0] w_idx_plus1;
   logic [HAW-1:0] w_addr;
   logic [AW:0]   w_in_use_inc;
   logic          w_do_alloc;
   logic          w_alloc_pop;
   logic [AW-1:0] w_alloc_id;
   logic          w_do_free;
   logic          w_do_write;
   logic          w_push;
   logic          w_pop;
   logic [AW-1:0] w_stk_top;
   logic          w_stk_empty;

   // Reset synchronizer: internal reset releases two edges after reset_n rises.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end
   assign w_rst_n = r_rst_sync[1];

   assign cmd_ready  = w_rst_n && (!r_rsp_valid || rsp_ready);
   assign w_fire     = cmd_valid && cmd_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp.data[MemoryElementWidth-1:0];
   assign rsp_err    = r_rsp.err;
   assign in_use     = r_in_use;
   assign high_water = r_high_water;

   assign w_op           = op_t'(cmd_op);
   assign w_arr_in_range = (32'(cmd_array) < NArrays);
   assign w_arr_live     = w_arr_in_range && r_alloc[cmd_array];
   assign w_cur_len      = w_arr_in_range ? r_len[cmd_array] : '0;
   assign w_idx_in_area  = (32'(cmd_index) < NArea);
   assign w_idx_plus1    = LW'(cmd_index) + LEN_ONE;
   assign w_idx_in_len   = (LW'(cmd_index) < w_cur_len);
   assign w_can_fresh    = (32'(r_fresh) < NArrays);
   assign w_in_use_inc   = r_in_use + CNT_ONE;
   // Element address; HAW bits always hold the largest legal address.
   assign w_addr = HAW'(cmd_array) * HAW'(NArea) + HAW'(cmd_index);

   assign w_push = w_fire && w_do_free;
   assign w_pop  = w_fire && w_alloc_pop;

   array_free_stack #(
      .NArrays (NArrays),
      .AW      (AW)
   ) u_free_stack (
      .clock     (clock),
      .reset_n   (w_rst_n),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_push_id (cmd_array),
      .o_top     (w_stk_top),
      .o_empty   (w_stk_empty)
   );

   // Command decode: pick the action and build the response for this command.
   always_comb begin
      w_rsp       = '0;
      w_do_alloc  = 1'b0;
      w_alloc_pop = 1'b0;
      w_alloc_id  = '0;
      w_do_free   = 1'b0;
      w_do_write  = 1'b0;
      case (w_op)
         OP_ALLOC: begin
            if (!w_stk_empty) begin
               w_do_alloc  = 1'b1;
               w_alloc_pop = 1'b1;
               w_alloc_id  = w_stk_top;
            end else if (w_can_fresh) begin
               w_do_alloc = 1'b1;
               w_alloc_id = r_fresh[AW-1:0];
            end else begin
               w_rsp.err = 1'b1;
            end
            if (w_do_alloc) begin
               w_rsp.data = RSP_DW'(w_alloc_id);
            end
         end
         OP_FREE: begin
            if (w_arr_live) begin
               w_do_free = 1'b1;
            end else begin
               w_rsp.err = 1'b1;
            end
         end
         OP_READ: begin
            if (w_arr_live && w_idx_in_len) begin
               w_rsp.data = RSP_DW'(r_heap[w_addr]);
            end else begin
               w_rsp.err = 1'b1;
            end
         end
         OP_WRITE: begin
            if (w_arr_live && w_idx_in_area) begin
               w_do_write = 1'b1;
            end else begin
               w_rsp.err = 1'b1;
            end
         end
         OP_SIZE: begin
            if (w_arr_live) begin
               w_rsp.data = RSP_DW'(w_cur_len);
            end else begin
               w_rsp.err = 1'b1;
            end
         end
         default: begin
            w_rsp.err = 1'b1;
         end
      endcase
   end

   // Response register: load on command accept, clear once consumed.
   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp       <= '0;
      end else if (w_fire) begin
         r_rsp_valid <= 1'b1;
         r_rsp       <= w_rsp;
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   // Allocation bookkeeping: allocated bits, lengths, counters.
   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_alloc      <= '0;
         r_fresh      <= '0;
         r_in_use     <= '0;
         r_high_water <= '0;
         for (int i = 0; i < int'(NArrays); i++) begin
            r_len[i] <= '0;
         end
      end else if (w_fire) begin
         if (w_do_alloc) begin
            r_alloc[w_alloc_id] <= 1'b1;
            r_len[w_alloc_id]   <= '0;
            r_in_use            <= w_in_use_inc;
            if (w_in_use_inc > r_high_water) begin
               r_high_water <= w_in_use_inc;
            end
            if (!w_alloc_pop) begin
               r_fresh <= r_fresh + CNT_ONE;
            end
         end
         if (w_do_free) begin
            r_alloc[cmd_array] <= 1'b0;
            r_in_use           <= r_in_use - CNT_ONE;
         end
         if (w_do_write && (w_idx_plus1 > w_cur_len)) begin
            r_len[cmd_array] <= w_idx_plus1;
         end
      end
   end

   // Heap storage: synchronous write, contents survive reset.
   always_ff @(posedge clock) begin
      if (w_fire && w_do_write) begin
         r_heap[w_addr] <= cmd_data;
      end
   end

   // Response record bits above the element width are always zero.
   if (MemoryElementWidth < RSP_DW) begin : g_rsp_pad
      logic w_unused_rsp_pad;
      assign w_unused_rsp_pad = ^r_rsp.data[RSP_DW-1:MemoryElementWidth];
   end

endmodule

// File: tb/tb_array_heap.sv
// Directed bench for array_heap: commands are driven from one initial block,
// expected responses are queued as each command is issued and compared by a
// monitor as the DUT hands responses over.
module tb_array_heap;
  import array_heap_pkg::*;

  localparam int unsigned W  = 12;
  localparam int unsigned NA = 4;
  localparam int unsigned NE = 3;
  localparam int unsigned AW = 2;
  localparam int unsigned IW = 2;

  logic          clock;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_array;
  logic [IW-1:0] cmd_index;
  logic [W-1:0]  cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_err;
  logic [AW:0]   in_use;
  logic [AW:0]   high_water;

  array_heap #(
    .MemoryElementWidth (W),
    .NArrays            (NA),
    .NArea              (NE)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_array  (cmd_array),
    .cmd_index  (cmd_index),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .in_use     (in_use),
    .high_water (high_water)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_rsp    = 0;
  int unsigned n_cyc    = 0;

  logic [W:0] exp_q[$];
  string      tag_q[$];

  always @(posedge clock) n_cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor: a response transfers at the next rising edge
  always @(negedge clock) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      n_rsp++;
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_rsp: observed 0x%0h with empty queue, expected no response", {rsp_err, rsp_data});
      end
      if (exp_q.size() != 0) begin
        logic [W:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, 32'({rsp_err, rsp_data}), 32'(e));
      end
    end
  end

  // driver: entered and left at 1 time unit after a rising edge
  task automatic send(input logic [2:0] op, input logic [AW-1:0] arr, input logic [IW-1:0] idx,
                      input logic [W-1:0] data, input logic exp_err, input logic [W-1:0] exp_data,
                      input string tag, output int waited);
    logic acc;
    logic accepted;
    exp_q.push_back({exp_err, exp_data});
    tag_q.push_back(tag);
    cmd_op    = op;
    cmd_array = arr;
    cmd_index = idx;
    cmd_data  = data;
    cmd_valid = 1'b1;
    waited    = 0;
    accepted  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      acc = cmd_ready;
      @(posedge clock);
      #1;
      if (acc) begin
        accepted = 1'b1;
        break;
      end
      waited++;
    end
    cmd_valid = 1'b0;
    cmd_op    = $urandom_range(0, 7);
    cmd_array = $urandom_range(0, NA - 1);
    cmd_index = $urandom_range(0, 3);
    cmd_data  = $urandom_range(0, (1 << W) - 1);
    check({tag, "_accepted"}, 32'(accepted), 32'd1);
  endtask

  task automatic cmd(input logic [2:0] op, input logic [AW-1:0] arr, input logic [IW-1:0] idx,
                     input logic [W-1:0] data, input logic exp_err, input logic [W-1:0] exp_data,
                     input string tag);
    int w;
    send(op, arr, idx, data, exp_err, exp_data, tag, w);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clock);
      #1;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    exp_q.delete();
    tag_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic check_counts(input string tag, input int iu, input int hw);
    check({tag, "_in_use"}, 32'(in_use), 32'(iu));
    check({tag, "_high_water"}, 32'(high_water), 32'(hw));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int tot_wait;
    int unsigned c0;
    int unsigned r0;
    reset_n   = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    cmd_op    = '0;
    cmd_array = '0;
    cmd_index = '0;
    cmd_data  = '0;
    #2;

    // reset state
    do_reset();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_counts("rst", 0, 0);

    // fill all arrays, then one too many
    cmd(OP_ALLOC, 0, 0, 0, 1'b0, 12'd0, "t1_alloc0");
    cmd(OP_ALLOC, 0, 0, 0, 1'b0, 12'd1, "t1_alloc1");
    cmd(OP_ALLOC, 0, 0, 0, 1'b0, 12'd2, "t1_alloc2");
    cmd(OP_ALLOC, 0, 0, 0, 1'b0, 12'd3, "t1_alloc3");
    cmd(OP_ALLOC, 0, 0, 0, 1'b1, 12'd0, "t1_alloc_full");
    drain();
    check_counts("t1", 4, 4);

    // writes extend length, reads, out-of-area write
    do_reset();
    cmd(OP_ALLOC, 0, 0, 0, 1'b0, 12'd0, "t2_alloc");
    cmd(OP_READ, 0, 0, 0, 1'b1, 12'd0, "t2_read_empty");
    cmd(OP_WRITE, 0, 0, 12'd1, 1'b0, 12'd0, "t2_wr0");
    cmd(OP_WRITE, 0, 1, 12'd2, 1'b0, 12'd0, "t2_wr1");
    cmd(OP_WRITE, 0, 2, 12'd3, 1'b0, 12'd0, "t2_wr2");
    cmd(OP_SIZE, 0, 0, 0, 1'b0, 12'd3, "t2_size");
    cmd(OP_READ, 0, 1, 0, 1'b0, 12'd2, "t2_rd1");
    cmd(OP_WRITE, 0, 3, 12'd9, 1'b1, 12'd0, "t2_wr_oob");
    cmd(OP_SIZE, 0, 0, 0, 1'b0, 12'd3, "t2_size_after_oob");
    cmd(OP_WRITE, 0, 1, 12'h5A5, 1'b0, 12'd0, "t2_wr1_new");
    cmd(OP_READ, 0, 1, 0, 1'b0, 12'h5A5, "t2_rd1_write_first");
    cmd(OP_READ, 0, 0, 0, 1'b0, 12'd1, "t2_rd0");
    cmd(3'd5, 0, 0, 0, 1'b1, 12'd0, "t2_illegal_op");
    cmd(OP_SIZE, 1, 0, 0, 1'b1, 12'd0, "t2_size_unalloc");
    drain();
    check_counts("t2", 1, 1);

    // LIFO reuse of freed ids
    do_reset();
    cmd(OP_ALLOC, 0, 0, 0, 1'b0, 12'd0, "t3_alloc0");
    cmd(OP_ALLOC, 0, 0, 0, 1'b0, 12'd1, "t3_alloc1");
    cmd(OP_WRITE, 0, 1, 12'd4, 1'b0, 12'd0, "t3_wr");
    cmd(OP_FREE, 1, 0, 0, 1'b0, 12'd0, "t3_free1");
    cmd(OP_FREE, 0, 0, 0, 1'b0, 12'd0, "t3_free0");
    drain();
    check_counts("t3_freed", 0, 2);
    cmd(OP_ALLOC, 0, 0, 0, 1'b0, 12'd0, "t3_realloc0");
    cmd(OP_ALLOC, 0, 0, 0, 1'b0, 12'd1, "t3_realloc1");
    cmd(OP_SIZE, 0, 0, 0, 1'b0, 12'd0, "t3_size0");
    cmd(OP_ALLOC, 0, 0, 0, 1'b0, 12'd2, "t3_alloc_fresh2");
    drain();
    check_counts("t3", 3, 3);

    // free, double free, read after free
    do_reset();
    cmd(OP_ALLOC, 0, 0, 0, 1'b0, 12'd0, "t4_alloc");
    cmd(OP_WRITE, 0, 2, 12'd7, 1'b0, 12'd0, "t4_wr2");
    cmd(OP_SIZE, 0, 0, 0, 1'b0, 12'd3, "t4_size");
    cmd(OP_READ, 0, 2, 0, 1'b0, 12'd7, "t4_rd2");
    cmd(OP_FREE, 3, 0, 0, 1'b1, 12'd0, "t4_free_never");
    cmd(OP_FREE, 0, 0, 0, 1'b0, 12'd0, "t4_free");
    cmd(OP_FREE, 0, 0, 0, 1'b1, 12'd0, "t4_double_free");
    cmd(OP_READ, 0, 0, 0, 1'b1, 12'd0, "t4_rd_freed");
    drain();
    check_counts("t4", 0, 1);

    // backpressure: response held while rsp_ready is low
    do_reset();
    rsp_ready = 1'b0;
    cmd(OP_ALLOC, 0, 0, 0, 1'b0, 12'd0, "t5_alloc");
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t5_cmd_ready_low", 32'(cmd_ready), 32'd0);
      check("t5_rsp_valid_held", 32'(rsp_valid), 32'd1);
      check("t5_rsp_stable", 32'({rsp_err, rsp_data}), 32'd0);
    end
    @(posedge clock);
    #1;
    rsp_ready = 1'b1;
    send(OP_SIZE, 0, 0, 0, 1'b0, 12'd0, "t5_release_size", w);
    check("t5_release_wait", 32'(w), 32'd0);
    drain();
    c0 = n_cyc;
    r0 = n_rsp;
    tot_wait = 0;
    for (int i = 0; i < 8; i++) begin
      send(OP_SIZE, 0, 0, 0, 1'b0, 12'd0, "t5_b2b_size", w);
      tot_wait += w;
    end
    @(negedge clock);
    #1;
    check("t5_b2b_wait", 32'(tot_wait), 32'd0);
    check("t5_b2b_rsp_count", 32'(n_rsp - r0), 32'd8);
    check("t5_b2b_cycles", 32'(n_cyc - c0), 32'd8);
    @(posedge clock);
    #1;
    drain();

    // asynchronous reset with a response pending
    cmd(OP_ALLOC, 0, 0, 0, 1'b0, 12'd1, "t6_alloc1");
    cmd(OP_ALLOC, 0, 0, 0, 1'b0, 12'd2, "t6_alloc2");
    drain();
    check_counts("t6_pre", 3, 3);
    rsp_ready = 1'b0;
    cmd(OP_ALLOC, 0, 0, 0, 1'b0, 12'd3, "t6_dropped");
    check("t6_pending", 32'(rsp_valid), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_async_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_async_cmd_ready", 32'(cmd_ready), 32'd0);
    check_counts("t6_async", 0, 0);
    exp_q.delete();
    tag_q.delete();
    @(posedge clock);
    #1;
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    cmd(OP_ALLOC, 0, 0, 0, 1'b0, 12'd0, "t6_alloc_after_rst");
    cmd(OP_SIZE, 1, 0, 0, 1'b1, 12'd0, "t6_size_lost");
    drain();
    check_counts("t6_post", 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
